countdown_display: RTL and testbench

COUNTDOWN_DISPLAY -- requirements
Module: countdown_display

---
 rtl/countdown_pkg.sv | 51 +++++
 rtl/bin2bcd_seq.sv | 84 ++++++++
 rtl/countdown_display.sv | 140 ++++++++++++++
 tb/tb_countdown_display.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// ============================================================================
// countdown_pkg
// Shared types and constants for the countdown display: converter state enum,
// active-low seven-segment codes {g,f,e,d,c,b,a} and the digit count.
// Revision: 1.0
// ============================================================================
`default_nettype none

package countdown_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } conv_state_e;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam int NUM_DIGITS = 4;

   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      logic [6:0] code;
      case (digit)
         4'd0:    code = SEG_0;
         4'd1:    code = SEG_1;
         4'd2:    code = SEG_2;
         4'd3:    code = SEG_3;
         4'd4:    code = SEG_4;
         4'd5:    code = SEG_5;
         4'd6:    code = SEG_6;
         4'd7:    code = SEG_7;
         4'd8:    code = SEG_8;
         4'd9:    code = SEG_9;
         default: code = SEG_BLANK;
      endcase
      return code;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// bin2bcd_seq
// Sequential double-dabble converter: 8-bit binary to hundreds/tens/ones BCD,
// one shift per cycle, followed by a single COMMIT cycle that pulses done.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bin2bcd_seq
   import countdown_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [7:0] bin,
   output logic       busy,
   output logic       done,
   output logic [1:0] hundreds,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   conv_state_e state_q, state_d;
   logic [7:0]  bin_q, bin_d;
   logic [9:0]  bcd_q, bcd_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [3:0]  w_tens_adj;
   logic [3:0]  w_ones_adj;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
      end
   end

   // Hundreds never reaches 5 for an 8-bit input, so only tens/ones need the +3 fix-up.
   assign w_tens_adj = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
   assign w_ones_adj = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SHIFT;
               bin_d   = bin;
               bcd_d   = '0;
               cnt_d   = '0;
            end
         end
         ST_SHIFT: begin
            {bcd_d, bin_d} = {bcd_q[8], w_tens_adj, w_ones_adj, bin_q, 1'b0};
            cnt_d          = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q != ST_IDLE);
      done     = (state_q == ST_COMMIT);
      hundreds = bcd_q[9:8];
      tens     = bcd_q[7:4];
      ones     = bcd_q[3:0];
   end

endmodule

`default_nettype wire

// File: rtl/countdown_display.sv
// ============================================================================
// countdown_display
// Converts the countdown value to BCD, multiplexes three significant digits
// with leading-zero blanking, and blinks the display while the value is zero.
// Revision: 1.0
// ============================================================================
`default_nettype none

module countdown_display
   import countdown_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 250
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [7:0]            value,
   output logic [6:0]            seg,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  zero,
   output logic                  busy
);

   localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

   logic                  w_busy, w_done, w_start, w_tick;
   logic [1:0]            w_hund;
   logic [3:0]            w_tens, w_ones;
   logic [6:0]            w_seg_new;
   logic [NUM_DIGITS-1:0] w_an_new;

   logic [7:0]            last_q, last_d;
   logic                  force_q, force_d;
   logic [1:0]            hund_q, hund_d;
   logic [3:0]            tens_q, tens_d;
   logic [3:0]            ones_q, ones_d;
   logic                  zero_q, zero_d;
   logic [REF_W-1:0]      ref_q, ref_d;
   logic [1:0]            idx_q, idx_d;
   logic                  on_q, on_d;
   logic [BLK_W-1:0]      bcnt_q, bcnt_d;
   logic [6:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;

   bin2bcd_seq u_conv (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (w_start),
      .bin      (value),
      .busy     (w_busy),
      .done     (w_done),
      .hundreds (w_hund),
      .tens     (w_tens),
      .ones     (w_ones)
   );

   // Change detection is only armed while the converter is idle.
   assign w_start = !w_busy && ((value != last_q) || force_q);
   assign w_tick  = (ref_q == REF_MAX);

   always_comb begin
      last_d  = w_start ? value : last_q;
      force_d = w_start ? 1'b0 : force_q;
      ref_d   = w_tick ? '0 : ref_q + REF_W'(1);
      idx_d   = w_tick ? idx_q + 2'd1 : idx_q;
      hund_d  = w_done ? w_hund : hund_q;
      tens_d  = w_done ? w_tens : tens_q;
      ones_d  = w_done ? w_ones : ones_q;
      zero_d  = w_done ? (w_hund == 2'd0 && w_tens == 4'd0 && w_ones == 4'd0) : zero_q;
      on_d    = on_q;
      bcnt_d  = bcnt_q;
      if (!zero_d) begin
         on_d   = 1'b1;
         bcnt_d = '0;
      end else if (w_tick) begin
         if (bcnt_q == BLK_MAX) begin
            on_d   = !on_q;
            bcnt_d = '0;
         end else begin
            bcnt_d = bcnt_q + BLK_W'(1);
         end
      end
   end

   // Outputs are rebuilt from next-state values so a tick and a commit on the same edge agree.
   always_comb begin
      w_seg_new = SEG_BLANK;
      case (idx_d)
         2'd0: w_seg_new = seg_encode(ones_d);
         2'd1: w_seg_new = (hund_d == 2'd0 && tens_d == 4'd0) ? SEG_BLANK : seg_encode(tens_d);
         2'd2: w_seg_new = (hund_d == 2'd0) ? SEG_BLANK : seg_encode({2'b00, hund_d});
         2'd3: w_seg_new = SEG_BLANK;
         default: w_seg_new = SEG_BLANK;
      endcase
      w_an_new = on_d ? ~(NUM_DIGITS'(1) << idx_d) : '1;
      seg_d    = (w_tick || w_done) ? w_seg_new : seg_q;
      an_d     = (w_tick || w_done) ? w_an_new : an_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q  <= '0;
         force_q <= 1'b1;
         hund_q  <= '0;
         tens_q  <= '0;
         ones_q  <= '0;
         zero_q  <= 1'b1;
         ref_q   <= '0;
         idx_q   <= '0;
         on_q    <= 1'b1;
         bcnt_q  <= '0;
         seg_q   <= SEG_BLANK;
         an_q    <= '1;
      end else begin
         last_q  <= last_d;
         force_q <= force_d;
         hund_q  <= hund_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         zero_q  <= zero_d;
         ref_q   <= ref_d;
         idx_q   <= idx_d;
         on_q    <= on_d;
         bcnt_q  <= bcnt_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   assign seg  = seg_q;
   assign an   = an_q;
   assign zero = zero_q;
   assign busy = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_countdown_display.sv
// ============================================================================
// tb_countdown_display
// Directed bench for countdown_display with REFRESH_DIV=4, BLINK_DIV=2.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_countdown_display;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] value = 8'd0;
   logic [6:0] seg;
   logic [3:0] an;
   logic       zero;
   logic       busy;

   int total = 0;
   int bad   = 0;
   int ecnt  = 0;

   always #5 clk = ~clk;

   countdown_display #(
      .REFRESH_DIV (4),
      .BLINK_DIV   (2)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .value   (value),
      .seg     (seg),
      .an      (an),
      .zero    (zero),
      .busy    (busy)
   );

   // Edges are numbered from the last reset release; sampling is 1 ns after the edge.
   task automatic step_to(input int k);
      while (ecnt < k) begin
         @(posedge clk);
         ecnt++;
      end
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_disp(input string tag, input logic [3:0] an_exp, input logic [6:0] seg_exp);
      chk({tag, ".an"}, {4'b0, an}, {4'b0, an_exp});
      chk({tag, ".seg"}, {1'b0, seg}, {1'b0, seg_exp});
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      value = 8'd255;
      repeat (3) @(posedge clk);
      #1;
      chk_disp("rst", 4'b1111, 7'b1111111);
      chk("rst.zero", {7'b0, zero}, 8'd1);
      chk("rst.busy", {7'b0, busy}, 8'd0);
      reset_n = 1'b1;
      ecnt    = 0;

      // 255: conversion E1..E10, blink running before the first commit
      step_to(1);   chk("a.busy1", {7'b0, busy}, 8'd1);
      step_to(9);   chk("a.busy9", {7'b0, busy}, 8'd1);
      chk_disp("a.e9", 4'b1111, 7'b1111111);
      step_to(10);  chk("a.busy10", {7'b0, busy}, 8'd0);
      chk("a.zero", {7'b0, zero}, 8'd0);
      chk_disp("a.e10", 4'b1011, 7'b0100100);
      step_to(12);  chk_disp("a.e12", 4'b0111, 7'b1111111);
      step_to(16);  chk_disp("a.e16", 4'b1110, 7'b0010010);
      step_to(20);  chk_disp("a.e20", 4'b1101, 7'b0010010);
      chk("a.idle", {7'b0, busy}, 8'd0);

      // 7: leading zeros blanked
      value = 8'd7;
      step_to(30);  chk("b.busy", {7'b0, busy}, 8'd0);
      chk("b.zero", {7'b0, zero}, 8'd0);
      chk_disp("b.e30", 4'b0111, 7'b1111111);
      step_to(32);  chk_disp("b.e32", 4'b1110, 7'b1111000);
      step_to(36);  chk_disp("b.e36", 4'b1101, 7'b1111111);
      step_to(40);  chk_disp("b.e40", 4'b1011, 7'b1111111);

      // 100 then 42 mid-conversion
      value = 8'd100;
      step_to(44);  value = 8'd42;
      step_to(49);  chk("c.busy49", {7'b0, busy}, 8'd1);
      chk_disp("c.e49", 4'b1110, 7'b1111000);
      step_to(50);  chk("c.busy50", {7'b0, busy}, 8'd0);
      chk_disp("c.e50", 4'b1110, 7'b1000000);
      step_to(51);  chk("c.busy51", {7'b0, busy}, 8'd1);
      step_to(52);  chk_disp("c.e52", 4'b1101, 7'b1000000);
      step_to(56);  chk_disp("c.e56", 4'b1011, 7'b1111001);
      step_to(59);  chk("c.busy59", {7'b0, busy}, 8'd1);
      step_to(60);  chk("c.busy60", {7'b0, busy}, 8'd0);
      chk_disp("c.e60", 4'b0111, 7'b1111111);
      step_to(64);  chk_disp("c.e64", 4'b1110, 7'b0100100);
      step_to(68);  chk_disp("c.e68", 4'b1101, 7'b0011001);
      step_to(72);  chk_disp("c.e72", 4'b1011, 7'b1111111);

      // 0: blink every 8 cycles, then 1 restores steady scan
      value = 8'd0;
      step_to(82);  chk("d.zero", {7'b0, zero}, 8'd1);
      chk_disp("d.e82", 4'b1110, 7'b1000000);
      step_to(84);  chk("d.an84", {4'b0, an}, 8'b0000_1101);
      step_to(88);  chk("d.an88", {4'b0, an}, 8'b0000_1111);
      step_to(92);  chk("d.an92", {4'b0, an}, 8'b0000_1111);
      step_to(96);  chk("d.an96", {4'b0, an}, 8'b0000_1110);
      step_to(104); chk("d.an104", {4'b0, an}, 8'b0000_1111);
      value = 8'd1;
      step_to(114); chk("d.zero114", {7'b0, zero}, 8'd0);
      chk_disp("d.e114", 4'b1110, 7'b1111001);
      step_to(120); chk_disp("d.e120", 4'b1011, 7'b1111111);
      step_to(124); chk("d.an124", {4'b0, an}, 8'b0000_0111);
      step_to(128); chk_disp("d.e128", 4'b1110, 7'b1111001);
      step_to(132); chk("d.an132", {4'b0, an}, 8'b0000_1101);

      // 200 interrupted by reset during SHIFT
      value = 8'd200;
      step_to(137); chk("e.busy137", {7'b0, busy}, 8'd1);
      #2 reset_n = 1'b0;
      #1;
      chk_disp("e.rst", 4'b1111, 7'b1111111);
      chk("e.rst.zero", {7'b0, zero}, 8'd1);
      chk("e.rst.busy", {7'b0, busy}, 8'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      ecnt    = 0;
      step_to(1);   chk("e.busy1", {7'b0, busy}, 8'd1);
      step_to(9);   chk("e.busy9", {7'b0, busy}, 8'd1);
      chk("e.an9", {4'b0, an}, 8'b0000_1111);
      step_to(10);  chk("e.busy10", {7'b0, busy}, 8'd0);
      chk("e.zero", {7'b0, zero}, 8'd0);
      chk_disp("e.e10", 4'b1011, 7'b0100100);
      step_to(16);  chk_disp("e.e16", 4'b1110, 7'b1000000);
      step_to(20);  chk_disp("e.e20", 4'b1101, 7'b1000000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
